if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined CPU, directly upstream of the IF/ID pipeline register.
- Holds the PC and a small writable instruction memory.
- Each cycle it presents {pc, pc+4, instruction, valid} to the IF/ID register.
- Supports stall (hold), redirect (branch/jump flush) and halt on running off the end of instruction memory.

---
 rtl/if_fetch_stage.sv | 115 +++++++++++
 tb/tb_if_fetch_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, writable instruction memory and the
// registered {pc, pc+4, instr, valid} bundle feeding the IF/ID register.
module if_fetch_stage #(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DEPTH    = 64,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_en,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     imem_we,
  input  logic [$clog2(DEPTH)-1:0] imem_waddr,
  input  logic [31:0]              imem_wdata,
  output logic [AW-1:0]            if_pc,
  output logic [AW-1:0]            if_pc4,
  output logic [31:0]              if_instr,
  output logic                     if_valid,
  output logic                     halted
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] if_pc_d, if_pc4_d;
  logic [31:0]   if_instr_d;
  logic          if_valid_d, halted_d;

  logic [31:0]   imem [DEPTH];

  logic [AW-1:0] pc_plus4;
  logic [AW-1:0] target;
  logic          pc_in_range;
  logic          target_in_range;

  assign pc_plus4        = pc_q + AW'(4);
  assign target          = redirect_pc & ~AW'(3);
  assign pc_in_range     = (pc_q >> 2) < AW'(DEPTH);
  assign target_in_range = (target >> 2) < AW'(DEPTH);

  // Memory has no reset; the fetch path reads the pre-write word in a collision.
  always_ff @(posedge clk) begin
    if (imem_we && !rst) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      if_pc    <= '0;
      if_pc4   <= '0;
      if_instr <= '0;
      if_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      if_pc    <= if_pc_d;
      if_pc4   <= if_pc4_d;
      if_instr <= if_instr_d;
      if_valid <= if_valid_d;
      halted   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc;
    if_pc4_d   = if_pc4;
    if_instr_d = if_instr;
    if_valid_d = if_valid;
    halted_d   = halted;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_en) begin
          pc_d       = target;
          if_instr_d = '0;
          if_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (!pc_in_range) begin
          state_d    = HALT;
          if_instr_d = '0;
          if_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else begin
          if_instr_d = imem[pc_q[IW+1:2]];
          if_pc_d    = pc_q;
          if_pc4_d   = pc_plus4;
          if_valid_d = 1'b1;
          pc_d       = pc_plus4;
        end
      end
      HALT: begin
        if (redirect_en) begin
          pc_d = target;
          if (target_in_range) begin
            state_d  = RUN;
            halted_d = 1'b0;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run, all
// checked against a behavioural fetch model kept in the bench.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_we = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] if_pc, if_pc4, if_instr;
  logic        if_valid, halted;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] mmem [64];
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_halted;
  int          m_phase;   // 0 booting, 1 fetching, 2 stopped

  if_fetch_stage #(.AW(32), .DEPTH(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .if_pc(if_pc), .if_pc4(if_pc4),
    .if_instr(if_instr), .if_valid(if_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = '0; m_ipc4 = '0; m_instr = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_phase = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample at +1.
  task automatic step(input logic st, input logic re, input logic [31:0] rpc,
                      input logic we, input logic [5:0] wa, input logic [31:0] wd);
    logic [31:0] tgt;
    stall = st; redirect_en = re; redirect_pc = rpc;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    tgt = rpc / 4 * 4;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (re) begin
        m_pc = tgt; m_instr = 0; m_valid = 0;
      end else if (!st) begin
        if (m_pc / 4 >= 64) begin
          m_phase = 2; m_instr = 0; m_valid = 0; m_halted = 1;
        end else begin
          m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = mmem[m_pc / 4];
          m_valid = 1; m_pc = m_pc + 4;
        end
      end
    end else if (re) begin
      m_pc = tgt;
      if (tgt / 4 < 64) begin
        m_phase = 1; m_halted = 0;
      end
    end
    if (we) mmem[wa] = wd;
    #1;
    stall = 0; redirect_en = 0; imem_we = 0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] w;
    #3;
    checks += 5;
    if (if_pc !== 32'h0)    begin errors++; $display("FAIL reset_pc: got %h want 0", if_pc); end
    if (if_pc4 !== 32'h0)   begin errors++; $display("FAIL reset_pc4: got %h want 0", if_pc4); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", if_instr); end
    if (if_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    @(posedge clk); @(posedge clk); #4;
    rst = 0;
    model_reset();
    // Fill memory with fetch held off; the program words overwrite random fill.
    for (int i = 0; i < 64; i++) begin
      case (i)
        0: w = 32'h11;
        1: w = 32'h22;
        2: w = 32'h33;
        3: w = 32'h44;
        5: w = 32'hAA;
        default: w = $urandom;
      endcase
      step(1'b1, 1'b0, 32'h0, 1'b1, 6'(i), w);
    end
    #2 rst = 1;
    #2 rst = 0;
    model_reset();
    idle();
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", if_valid); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks += 4;
      if (if_pc !== 32'(4 * i))         begin errors++; $display("FAIL boot_pc%0d: got %h want %h", i, if_pc, 4 * i); end
      if (if_pc4 !== 32'(4 * i + 4))    begin errors++; $display("FAIL boot_pc4%0d: got %h want %h", i, if_pc4, 4 * i + 4); end
      if (if_instr !== 32'(17 * (i + 1))) begin errors++; $display("FAIL boot_instr%0d: got %h want %h", i, if_instr, 17 * (i + 1)); end
      if (if_valid !== 1'b1)            begin errors++; $display("FAIL boot_valid%0d: got %b want 1", i, if_valid); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
      checks += 3;
      if (if_pc !== 32'h8)     begin errors++; $display("FAIL stall_pc%0d: got %h want 8", i, if_pc); end
      if (if_instr !== 32'h33) begin errors++; $display("FAIL stall_instr%0d: got %h want 33", i, if_instr); end
      if (if_valid !== 1'b1)   begin errors++; $display("FAIL stall_valid%0d: got %b want 1", i, if_valid); end
    end
    idle();
    checks += 3;
    if (if_pc !== 32'hC)     begin errors++; $display("FAIL unstall_pc: got %h want c", if_pc); end
    if (if_pc4 !== 32'h10)   begin errors++; $display("FAIL unstall_pc4: got %h want 10", if_pc4); end
    if (if_instr !== 32'h44) begin errors++; $display("FAIL unstall_instr: got %h want 44", if_instr); end
  endtask

  task automatic test_redirect_stall();
    step(1'b1, 1'b1, 32'h0000000E, 1'b0, 6'd0, 32'h0);
    checks += 3;
    if (if_valid !== 1'b0)   begin errors++; $display("FAIL redir_valid: got %b want 0", if_valid); end
    if (if_instr !== 32'h0)  begin errors++; $display("FAIL redir_instr: got %h want 0", if_instr); end
    if (if_pc !== 32'hC)     begin errors++; $display("FAIL redir_pc_hold: got %h want c", if_pc); end
    idle();
    checks += 3;
    if (if_pc !== 32'hC)     begin errors++; $display("FAIL redir_fetch_pc: got %h want c", if_pc); end
    if (if_instr !== 32'h44) begin errors++; $display("FAIL redir_fetch_instr: got %h want 44", if_instr); end
    if (if_valid !== 1'b1)   begin errors++; $display("FAIL redir_fetch_valid: got %b want 1", if_valid); end
  endtask

  task automatic test_halt();
    step(1'b0, 1'b1, 32'hF8, 1'b0, 6'd0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      idle();
      checks += 3;
      if (if_pc !== 32'(32'hF8 + 4 * i)) begin errors++; $display("FAIL halt_pc%0d: got %h want %h", i, if_pc, 32'hF8 + 4 * i); end
      if (if_instr !== mmem[62 + i])   begin errors++; $display("FAIL halt_instr%0d: got %h want %h", i, if_instr, mmem[62 + i]); end
      if (if_valid !== 1'b1)           begin errors++; $display("FAIL halt_valid%0d: got %b want 1", i, if_valid); end
    end
    idle();
    checks += 3;
    if (halted !== 1'b1)    begin errors++; $display("FAIL halt_flag: got %b want 1", halted); end
    if (if_valid !== 1'b0)  begin errors++; $display("FAIL halt_bubble: got %b want 0", if_valid); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL halt_instr: got %h want 0", if_instr); end
    step(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    checks += 2;
    if (halted !== 1'b1)   begin errors++; $display("FAIL halt_stall_flag: got %b want 1", halted); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_stall_valid: got %b want 0", if_valid); end
    step(1'b0, 1'b1, 32'h200, 1'b0, 6'd0, 32'h0);
    idle();
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_oor_redirect: got %b want 1", halted); end
    step(1'b0, 1'b1, 32'h0, 1'b0, 6'd0, 32'h0);
    checks += 2;
    if (halted !== 1'b0)   begin errors++; $display("FAIL recover_flag: got %b want 0", halted); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL recover_bubble: got %b want 0", if_valid); end
    idle();
    checks += 3;
    if (if_pc !== 32'h0)     begin errors++; $display("FAIL recover_pc: got %h want 0", if_pc); end
    if (if_instr !== 32'h11) begin errors++; $display("FAIL recover_instr: got %h want 11", if_instr); end
    if (if_valid !== 1'b1)   begin errors++; $display("FAIL recover_valid: got %b want 1", if_valid); end
  endtask

  task automatic test_collision();
    step(1'b0, 1'b1, 32'h14, 1'b0, 6'd0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 6'd5, 32'hBB);
    checks += 2;
    if (if_pc !== 32'h14)    begin errors++; $display("FAIL coll_pc: got %h want 14", if_pc); end
    if (if_instr !== 32'hAA) begin errors++; $display("FAIL coll_old: got %h want aa", if_instr); end
    step(1'b0, 1'b1, 32'h14, 1'b0, 6'd0, 32'h0);
    idle();
    checks++;
    if (if_instr !== 32'hBB) begin errors++; $display("FAIL coll_new: got %h want bb", if_instr); end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    for (int i = 0; i < 300; i++) begin
      rpc = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 'h11F));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rpc,
           $urandom_range(0, 4) == 0, 6'($urandom_range(0, 63)), $urandom);
      checks++;
      if (if_pc !== m_ipc || if_pc4 !== m_ipc4 || if_instr !== m_instr ||
          if_valid !== m_valid || halted !== m_halted) begin
        errors++;
        $display("FAIL rand%0d: got pc=%h pc4=%h instr=%h v=%b h=%b want pc=%h pc4=%h instr=%h v=%b h=%b",
                 i, if_pc, if_pc4, if_instr, if_valid, halted, m_ipc, m_ipc4, m_instr, m_valid, m_halted);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 32'h0, 1'b0, 6'd0, 32'h0);
    idle(); idle();
    checks++;
    if (if_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid: got %b want 1", if_valid); end
    #2 rst = 1;
    #1;
    checks += 5;
    if (if_pc !== 32'h0)    begin errors++; $display("FAIL areset_pc: got %h want 0", if_pc); end
    if (if_pc4 !== 32'h0)   begin errors++; $display("FAIL areset_pc4: got %h want 0", if_pc4); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL areset_instr: got %h want 0", if_instr); end
    if (if_valid !== 1'b0)  begin errors++; $display("FAIL areset_valid: got %b want 0", if_valid); end
    if (halted !== 1'b0)    begin errors++; $display("FAIL areset_halted: got %b want 0", halted); end
    #1 rst = 0;
    model_reset();
    idle();
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL areset_boot: got %b want 0", if_valid); end
    idle();
    checks += 3;
    if (if_pc !== 32'h0)      begin errors++; $display("FAIL areset_fetch_pc: got %h want 0", if_pc); end
    if (if_instr !== mmem[0]) begin errors++; $display("FAIL areset_fetch_instr: got %h want %h", if_instr, mmem[0]); end
    if (if_valid !== 1'b1)    begin errors++; $display("FAIL areset_fetch_valid: got %b want 1", if_valid); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_collision();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
